// File: rtl/td_pulse_scheduler_if.sv
// Requester, detector-command and status bundle of the transition-detector pulse scheduler.
// The scheduler connects through master; the requester/detector side connects through slave.
interface td_pulse_scheduler_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] abort;
   logic [NREQ-1:0] gnt;
   logic [31:0]     det_in;
   logic [31:0]     det_out;
   logic            busy;
   logic            done;
   logic            aborted;
   logic            err_timeout;
   logic            err_len;

   modport master (
      input  req, abort, det_out,
      output gnt, det_in, busy, done, aborted, err_timeout, err_len
   );

   modport slave (
      output req, abort, det_out,
      input  gnt, det_in, busy, done, aborted, err_timeout, err_len
   );
endinterface

// File: rtl/td_pulse_scheduler.sv
// Round-robin scheduler sharing one transition detector between NREQ requesters:
// issues a start command, measures the returned pulse, and handles timeout/abort/drain.

module td_pulse_scheduler_chk #(
   parameter int NREQ = 4
) (
   input logic            i_clk,
   input logic            i_rst,
   input logic [NREQ-1:0] i_gnt,
   input logic [31:0]     i_det_in,
   input logic            i_busy,
   input logic            i_done,
   input logic            i_aborted,
   input logic            i_err_timeout,
   input logic            i_err_len
);
   a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(i_gnt));
   a_busy_owner:  assert property (@(posedge i_clk) disable iff (i_rst) i_busy |-> $onehot(i_gnt));
   a_idle_free:   assert property (@(posedge i_clk) disable iff (i_rst) !i_busy |-> (i_gnt == {NREQ{1'b0}}));
   a_pulse_excl:  assert property (@(posedge i_clk) disable iff (i_rst) $onehot0({i_done, i_aborted, i_err_timeout}));
   a_len_w_done:  assert property (@(posedge i_clk) disable iff (i_rst) i_err_len |-> i_done);
   a_cmd_legal:   assert property (@(posedge i_clk) disable iff (i_rst)
                     (i_det_in == 32'h0000_0000) || (i_det_in == 32'hFFFF_FFFE) || (i_det_in == 32'hFFFF_FFFF));
endmodule

module td_pulse_scheduler #(
   parameter int NREQ      = 4,
   parameter int PULSE_LEN = 4,
   parameter int TIMEOUT   = 8,
   parameter int DRAIN_CYC = 8
) (
   input logic                  clk,
   input logic                  reset,
   td_pulse_scheduler_if.master io_bus
);
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int M1   = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
   localparam int CMAX = (M1 > 2 * PULSE_LEN) ? M1 : 2 * PULSE_LEN;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_ABORT = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   localparam logic [31:0]     CMD_NONE  = 32'h0000_0000;
   localparam logic [31:0]     CMD_START = 32'hFFFF_FFFE;
   localparam logic [31:0]     CMD_CLEAR = 32'hFFFF_FFFF;
   localparam logic [CW-1:0]   C_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0]   C_ONE     = CW'(1);
   localparam logic [CW-1:0]   C_TIMEOUT = CW'(TIMEOUT);
   localparam logic [CW-1:0]   C_LEN     = CW'(PULSE_LEN);
   localparam logic [CW-1:0]   C_SAT     = CW'(2 * PULSE_LEN);
   localparam logic [CW-1:0]   C_DRAIN   = CW'(DRAIN_CYC);
   localparam logic [PW-1:0]   P_ZERO    = {PW{1'b0}};
   localparam logic [PW-1:0]   P_ONE     = PW'(1);
   localparam logic [PW-1:0]   P_LAST    = PW'(NREQ - 1);
   localparam logic [NREQ-1:0] G_ZERO    = {NREQ{1'b0}};

   logic [2:0]      r_state,       w_state_nx;
   logic [CW-1:0]   r_cnt,         w_cnt_nx;
   logic [PW-1:0]   r_own,         w_own_nx;
   logic [PW-1:0]   r_ptr,         w_ptr_nx;
   logic [NREQ-1:0] r_gnt,         w_gnt_nx;
   logic [31:0]     r_det_in,      w_det_in_nx;
   logic            r_busy,        w_busy_nx;
   logic            r_done,        w_done_nx;
   logic            r_aborted,     w_aborted_nx;
   logic            r_err_timeout, w_err_timeout_nx;
   logic            r_err_len,     w_err_len_nx;

   logic            w_found;
   logic [PW-1:0]   w_win;
   logic            w_det_one;
   logic            w_abort_own;

   function automatic logic [NREQ-1:0] f_onehot(input logic [PW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = {NREQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Anything other than exactly 1 on the detector output counts as "no pulse".
   assign w_det_one   = (io_bus.det_out == 32'h0000_0001);
   assign w_abort_own = io_bus.abort[r_own];

   // Round-robin winner search starting at r_ptr.
   always_comb begin : rr_search
      int            w_sum;
      logic [PW-1:0] w_idx;
      logic          w_hit;
      w_found = 1'b0;
      w_win   = P_ZERO;
      w_sum   = 0;
      w_idx   = P_ZERO;
      w_hit   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum   = int'(r_ptr) + i;
         w_idx   = PW'((w_sum >= NREQ) ? (w_sum - NREQ) : w_sum);
         w_hit   = ~w_found & io_bus.req[w_idx];
         w_win   = w_hit ? w_idx : w_win;
         w_found = w_found | w_hit;
      end
   end

   // Transaction FSM next state and next registered outputs.
   always_comb begin : fsm_next
      w_state_nx       = r_state;
      w_cnt_nx         = r_cnt;
      w_own_nx         = r_own;
      w_ptr_nx         = r_ptr;
      w_gnt_nx         = r_gnt;
      w_det_in_nx      = CMD_NONE;
      w_done_nx        = 1'b0;
      w_aborted_nx     = 1'b0;
      w_err_timeout_nx = 1'b0;
      w_err_len_nx     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nx = C_ZERO;
            if (w_found) begin
               w_state_nx  = S_ISSUE;
               w_own_nx    = w_win;
               w_ptr_nx    = (w_win == P_LAST) ? P_ZERO : (w_win + P_ONE);
               w_gnt_nx    = f_onehot(w_win);
               w_det_in_nx = CMD_START;
            end else begin
               w_gnt_nx    = G_ZERO;
            end
         end
         S_ISSUE: begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = C_ONE;
         end
         S_WAIT: begin
            // Owner abort outranks a same-cycle detector edge and the timeout.
            if (w_abort_own) begin
               w_state_nx   = S_ABORT;
               w_det_in_nx  = CMD_CLEAR;
               w_aborted_nx = 1'b1;
               w_cnt_nx     = C_ZERO;
            end else if (w_det_one) begin
               w_state_nx   = S_PULSE;
               w_cnt_nx     = C_ONE;
            end else if (r_cnt >= C_TIMEOUT) begin
               w_state_nx       = S_IDLE;
               w_err_timeout_nx = 1'b1;
               w_gnt_nx         = G_ZERO;
               w_cnt_nx         = C_ZERO;
            end else begin
               w_cnt_nx = r_cnt + C_ONE;
            end
         end
         S_PULSE: begin
            if (w_abort_own) begin
               w_state_nx   = S_ABORT;
               w_det_in_nx  = CMD_CLEAR;
               w_aborted_nx = 1'b1;
               w_cnt_nx     = C_ZERO;
            end else if (w_det_one) begin
               w_cnt_nx     = (r_cnt >= C_SAT) ? r_cnt : (r_cnt + C_ONE);
            end else begin
               w_state_nx   = S_IDLE;
               w_done_nx    = 1'b1;
               w_err_len_nx = (r_cnt != C_LEN);
               w_gnt_nx     = G_ZERO;
               w_cnt_nx     = C_ZERO;
            end
         end
         S_ABORT: begin
            w_state_nx = S_DRAIN;
            w_cnt_nx   = C_ONE;
         end
         S_DRAIN: begin
            if (r_cnt >= C_DRAIN) begin
               w_state_nx = S_IDLE;
               w_gnt_nx   = G_ZERO;
               w_cnt_nx   = C_ZERO;
            end else begin
               w_cnt_nx   = r_cnt + C_ONE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = G_ZERO;
            w_cnt_nx   = C_ZERO;
         end
      endcase
      w_busy_nx = (w_state_nx != S_IDLE);
   end

   // State, counters and all outputs are registered; reset clears them at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= C_ZERO;
         r_own         <= P_ZERO;
         r_ptr         <= P_ZERO;
         r_gnt         <= G_ZERO;
         r_det_in      <= CMD_NONE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_len     <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_own         <= w_own_nx;
         r_ptr         <= w_ptr_nx;
         r_gnt         <= w_gnt_nx;
         r_det_in      <= w_det_in_nx;
         r_busy        <= w_busy_nx;
         r_done        <= w_done_nx;
         r_aborted     <= w_aborted_nx;
         r_err_timeout <= w_err_timeout_nx;
         r_err_len     <= w_err_len_nx;
      end
   end

   assign io_bus.gnt         = r_gnt;
   assign io_bus.det_in      = r_det_in;
   assign io_bus.busy        = r_busy;
   assign io_bus.done        = r_done;
   assign io_bus.aborted     = r_aborted;
   assign io_bus.err_timeout = r_err_timeout;
   assign io_bus.err_len     = r_err_len;

   td_pulse_scheduler_chk #(.NREQ(NREQ)) u_chk (
      .i_clk         (clk),
      .i_rst         (reset),
      .i_gnt         (r_gnt),
      .i_det_in      (r_det_in),
      .i_busy        (r_busy),
      .i_done        (r_done),
      .i_aborted     (r_aborted),
      .i_err_timeout (r_err_timeout),
      .i_err_len     (r_err_len)
   );
endmodule
